// File: rtl/io_host_driver.sv
// io_host_driver
//   Host-side end of the accelerator IO port. Host words are queued in a small
//   FIFO and then played out on Din/load as one burst. After the burst, load is
//   held low for WAIT_CYCLES cycles. Then RES_COUNT Dout nibbles are sampled and
//   packed into result_word, which is offered to the host with valid/ready.
//
//   Optional feature: define IO_HOST_CHECKSUM_EN to add tx_checksum. It is the
//   XOR of every word driven with load=1 since the last accepted start.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_data/in_valid/in_ready host write side of the input FIFO
//   start, send_len           begin a transaction of send_len words (IDLE only)
//   Din, load                 word and strobe to the accelerator
//   Dout                      accelerator result nibble
//   result_word/valid/ready   packed result handshake to the host
//   busy, done                state != IDLE; 1-cycle pulse on result handshake
//   tx_checksum               (IO_HOST_CHECKSUM_EN only) XOR of sent words
module io_host_driver #(
    parameter int DIN_W       = 16,
    parameter int RES_W       = 4,
    parameter int RES_COUNT   = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_W-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       start,
    input  logic [7:0]                 send_len,
    output logic [DIN_W-1:0]           Din,
    output logic                       load,
    input  logic [RES_W-1:0]           Dout,
    output logic [RES_COUNT*RES_W-1:0] result_word,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy,
    output logic                       done
`ifdef IO_HOST_CHECKSUM_EN
    ,
    output logic [DIN_W-1:0]           tx_checksum
`endif
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(WAIT_CYCLES + 1);
    localparam int IW  = $clog2(RES_COUNT + 1);
    localparam int RW  = RES_COUNT * RES_W;

    typedef enum logic [2:0] {IDLE, SEND, WAIT, COLLECT, PRESENT} state_t;

    state_t state_q, state_d;

    // ---------------- input FIFO ----------------
    logic [DIN_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, in_ready_q;

    assign push    = in_valid && in_ready_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            in_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // ---------------- control / datapath registers ----------------
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]    res_idx_q, res_idx_d;
    logic [DIN_W-1:0] din_q, din_d;
    logic             load_q, load_d;
    logic [RW-1:0]    result_word_q, result_word_d;
    logic             result_valid_q, result_valid_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef IO_HOST_CHECKSUM_EN
    logic [DIN_W-1:0] chk_q, chk_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (send_len != 8'd0) ? SEND : WAIT;
            SEND:    if (word_cnt_q == 8'd0) state_d = WAIT;
            WAIT:    if (wait_cnt_q == WCW'(WAIT_CYCLES - 1)) state_d = COLLECT;
            COLLECT: if (res_idx_q == IW'(RES_COUNT - 1)) state_d = PRESENT;
            PRESENT: if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values. Din is only overwritten on a pop, so it
    // holds the last driven word through stalls and after the burst.
    always_comb begin
        pop            = 1'b0;
        word_cnt_d     = word_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        res_idx_d      = res_idx_q;
        din_d          = din_q;
        load_d         = 1'b0;
        result_word_d  = result_word_q;
        result_valid_d = result_valid_q;
        done_d         = 1'b0;
`ifdef IO_HOST_CHECKSUM_EN
        chk_d          = chk_q;
`endif
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                res_idx_d  = '0;
                if (start) begin
                    word_cnt_d = send_len;
`ifdef IO_HOST_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            SEND: begin
                if (word_cnt_q != 8'd0 && count_q != '0) begin
                    pop        = 1'b1;
                    din_d      = mem_q[rd_ptr_q];
                    load_d     = 1'b1;
                    word_cnt_d = word_cnt_q - 8'd1;
`ifdef IO_HOST_CHECKSUM_EN
                    chk_d      = chk_q ^ mem_q[rd_ptr_q];
`endif
                end
            end
            WAIT: wait_cnt_d = wait_cnt_q + WCW'(1);
            COLLECT: begin
                result_word_d[res_idx_q*RES_W +: RES_W] = Dout;
                res_idx_d = res_idx_q + IW'(1);
                if (res_idx_q == IW'(RES_COUNT - 1)) result_valid_d = 1'b1;
            end
            PRESENT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    done_d         = 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            res_idx_q      <= '0;
            din_q          <= '0;
            load_q         <= 1'b0;
            result_word_q  <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
`ifdef IO_HOST_CHECKSUM_EN
            chk_q          <= '0;
`endif
        end else begin
            word_cnt_q     <= word_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            res_idx_q      <= res_idx_d;
            din_q          <= din_d;
            load_q         <= load_d;
            result_word_q  <= result_word_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
`ifdef IO_HOST_CHECKSUM_EN
            chk_q          <= chk_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign Din          = din_q;
    assign load         = load_q;
    assign result_word  = result_word_q;
    assign result_valid = result_valid_q;
    assign done         = done_q;
    assign busy         = busy_q;
`ifdef IO_HOST_CHECKSUM_EN
    assign tx_checksum  = chk_q;
`endif

endmodule

// File: tb/tb_io_host_driver.sv
// Directed bench for io_host_driver. Inputs change and outputs are checked on
// the falling clock edge; the DUT acts on the rising edge.
module tb_io_host_driver;
    logic        clk, rst;
    logic [15:0] in_data;
    logic        in_valid, in_ready;
    logic        start;
    logic [7:0]  send_len;
    logic [15:0] Din;
    logic        load;
    logic [3:0]  Dout;
    logic [15:0] result_word;
    logic        result_valid, result_ready, busy, done;
`ifdef IO_HOST_CHECKSUM_EN
    logic [15:0] tx_checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_din [16];

    io_host_driver dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .send_len(send_len),
        .Din(Din), .load(load), .Dout(Dout),
        .result_word(result_word), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done)
`ifdef IO_HOST_CHECKSUM_EN
        , .tx_checksum(tx_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [15:0] w);
        in_data  = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Called in the first COLLECT cycle. Feeds four nibbles (first in [3:0]),
    // holds result_ready low for 'hold' cycles in PRESENT, then handshakes.
    task automatic collect(input logic [15:0] nibs, input int hold);
        for (int k = 0; k < 4; k++) begin
            Dout = nibs[k*4 +: 4];
            result_ready = (k == 1);   // must be ignored outside PRESENT
            step();
        end
        Dout = 4'h0;
        result_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("rv_hold", result_valid, 1);
            check("rw_hold", result_word, nibs);
            check("done_hold", done, 0);
            start    = (h == 2);       // must be ignored while busy
            send_len = 8'd1;
            step();
        end
        start = 1'b0;
        check("rv_present", result_valid, 1);
        check("rw_present", result_word, nibs);
        check("busy_present", busy, 1);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("done_pulse", done, 1);
        check("rv_cleared", result_valid, 0);
        check("busy_idle", busy, 0);
        step();
        check("done_one_cycle", done, 0);
        check("busy_stays_idle", busy, 0);
        check("load_idle", load, 0);
    endtask

    // FIFO already holds exp_din[0..n-1]; expects an unstalled burst.
    task automatic send_txn(input int n, input logic [15:0] nibs, input int hold);
        logic [15:0] x;
        x = '0;
        start    = 1'b1;
        send_len = 8'(n);
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (n != 0) begin
            check("load_before_first", load, 0);
            for (int k = 0; k < n; k++) begin
                step();
                check("load_burst", load, 1);
                check("din_burst", Din, exp_din[k]);
                x ^= exp_din[k];
            end
            step();
        end
        check("load_wait0", load, 0);
`ifdef IO_HOST_CHECKSUM_EN
        check("tx_checksum", tx_checksum, x);
`endif
        step();
        check("load_wait1", load, 0);
        step();
        collect(nibs, hold);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; start = 1'b0; send_len = '0;
        Dout = '0; result_ready = 1'b0;
        #3;
        check("rst_din", Din, 0);
        check("rst_load", load, 0);
        check("rst_rw", result_word, 0);
        check("rst_rv", result_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();

        // Basic 3-word burst
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
        exp_din[0] = 16'h1111; exp_din[1] = 16'h2222; exp_din[2] = 16'h3333;
        send_txn(3, 16'h4321, 0);

        // Checksum example burst
        push_word(16'h00F0); push_word(16'h0F00);
        exp_din[0] = 16'h00F0; exp_din[1] = 16'h0F00;
        send_txn(2, 16'h8421, 0);
`ifdef IO_HOST_CHECKSUM_EN
        check("tx_checksum_example", tx_checksum, 16'h0FF0);
`endif

        // Zero-length transaction
        send_txn(0, 16'h6789, 0);

        // Stall: second word arrives late; also PRESENT held for 10 cycles
        push_word(16'hAAAA);
        start = 1'b1; send_len = 8'd2;
        step();                                   // c1
        start = 1'b0;
        step();                                   // c2
        check("stall_load1", load, 1);
        check("stall_din1", Din, 16'hAAAA);
        for (int c = 3; c <= 6; c++) begin
            step();
            in_valid = 1'b0;
            check("stall_gap_load", load, 0);
            check("stall_gap_din", Din, 16'hAAAA);
            if (c == 5) begin in_data = 16'hBBBB; in_valid = 1'b1; end
        end
        step();                                   // c7
        check("stall_load2", load, 1);
        check("stall_din2", Din, 16'hBBBB);
        step();
        check("stall_wait0", load, 0);
        check("stall_din_held", Din, 16'hBBBB);
        step();
        check("stall_wait1", load, 0);
        step();
        collect(16'hDCBA, 10);

        // Fill: 9 back-to-back pushes, 9th dropped
        for (int i = 0; i < 9; i++) begin
            check("fill_in_ready", in_ready, (i < 8) ? 1 : 0);
            in_data  = 16'h0100 + 16'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("full_in_ready", in_ready, 0);
        for (int k = 0; k < 8; k++) exp_din[k] = 16'h0100 + 16'(k);
        send_txn(8, 16'h1357, 0);
        check("drained_in_ready", in_ready, 1);

        // FIFO must now be empty: a 1-word start stalls
        start = 1'b1; send_len = 8'd1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("empty_no_load", load, 0);
        end
        push_word(16'h7777);
        in_data = 16'h8888; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("pre_rst_load", load, 1);
        check("pre_rst_din", Din, 16'h7777);

        // Asynchronous reset mid-transaction
        #2 rst = 1'b1;
        #1;
        check("async_rst_load", load, 0);
        check("async_rst_din", Din, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();

        // Queued 0x8888 was discarded by reset
        start = 1'b1; send_len = 8'd1;
        step();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("post_rst_no_load", load, 0);
        end
        rst = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
